// File: rtl/variable_node_serial.sv
// variable_node_serial: iterative LDPC variable node; define VN_EARLY_TERM_EN to stop early on syndrome_ok.
module variable_node_serial #(
  parameter int num_connections = 3,
  parameter int prec = 4,
  parameter int max_iter = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic signed [prec-1:0]            llr_in,
  input  logic                              llr_valid,
  output logic                              llr_ready,
  input  logic [num_connections*prec-1:0]   Rwires,
  output logic [num_connections*prec-1:0]   Qwires,
  input  logic                              iter_en,
  input  logic                              syndrome_ok,
  output logic                              hard_bit,
  output logic                              done,
  input  logic                              out_ready,
  output logic [$clog2(max_iter+1)-1:0]     iter_count
);
  localparam int tw = prec + $clog2(num_connections + 1) + 1;
  localparam int cw = $clog2(max_iter + 1);
  localparam logic signed [tw-1:0] qmax = tw'((1 << (prec - 1)) - 1);
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  state_t state, state_n;
  logic signed [prec-1:0] llr_q, llr_sat;
  logic signed [tw-1:0] total;
  logic [num_connections*prec-1:0] q_upd;
  logic term, upd, last, load;
  function automatic logic signed [prec-1:0] sat(input logic signed [tw-1:0] x);
    return x > qmax ? prec'(qmax) : x < -qmax ? prec'(-qmax) : prec'(x);
  endfunction
`ifdef VN_EARLY_TERM_EN
  assign term = syndrome_ok;
`else
  logic unused_syndrome;
  assign unused_syndrome = syndrome_ok;
  assign term = 1'b0;
`endif
  assign llr_sat = sat(tw'(llr_in));
  assign load = state == IDLE && llr_valid && llr_ready;
  assign upd = state == ITER && iter_en && !term;
  assign last = iter_count == cw'(max_iter - 1);
  assign done = state == DONE;
  always_comb begin
    total = tw'(llr_q);
    q_upd = '0;
    for (int i = 0; i < num_connections; i++)
      total = total + tw'($signed(Rwires[prec*i +: prec]));
    for (int i = 0; i < num_connections; i++)
      q_upd[prec*i +: prec] = sat(total - tw'($signed(Rwires[prec*i +: prec])));
  end
  always_comb begin
    state_n = state == IDLE ? (load ? ITER : IDLE)
            : state == ITER ? ((term || (iter_en && last)) ? DONE : ITER)
            : (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      llr_ready <= 1'b0;
      llr_q <= '0;
      Qwires <= '0;
      hard_bit <= 1'b0;
      iter_count <= '0;
    end else begin
      llr_ready <= state_n == IDLE;
      if (load) begin
        llr_q <= llr_sat;
        Qwires <= {num_connections{llr_sat}};
        iter_count <= '0;
      end
      if (upd) begin
        Qwires <= q_upd;
        hard_bit <= total < 0;
        iter_count <= iter_count + 1'b1;
      end
    end
  end
endmodule
